// File: rtl/ccff_chain_loader_pkg.sv
// Shared types and helpers for the configuration-chain loader.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Number of DATA_W-bit words needed to carry len bits.
  function automatic int unsigned word_count(input int unsigned len, input int unsigned w);
    return (len + w - 1) / w;
  endfunction

endpackage

// File: rtl/ccff_chain_loader_rb_packer.sv
// Readback packer: gathers chain-tail bits into words and presents them
// through a single holding register on a valid/ready stream.
module ccff_rb_packer
  import ccff_loader_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              shift,
  input  logic              tail,
  input  logic              last_bit,
  input  logic              rb_ready,
  output logic [DATA_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              rb_last,
  output logic              can_accept,
  output logic              empty
);

  localparam int unsigned PC_W = $clog2(DATA_W + 1);
  localparam logic [PC_W-1:0] FULL_C = PC_W'(DATA_W);
  localparam logic [PC_W-1:0] ONE_C  = PC_W'(1);

  logic [DATA_W-1:0] pk_data;
  logic [DATA_W-1:0] hold_data;
  logic [DATA_W-1:0] pk_next;
  logic [DATA_W-1:0] pk_pad;
  logic [PC_W-1:0]   pk_cnt;
  logic [PC_W-1:0]   cnt_next;
  logic              pk_last;
  logic              hold_valid;
  logic              hold_last;
  logic              pk_full;
  logic              handshake;
  logic              hold_free;
  logic              word_done;

  // Next packer contents and whether a word completes on this edge.
  always_comb begin
    pk_full   = (pk_cnt == FULL_C);
    handshake = hold_valid && rb_ready;
    hold_free = !hold_valid || rb_ready;
    pk_next   = {pk_data[DATA_W-2:0], tail};
    cnt_next  = pk_cnt + ONE_C;
    word_done = shift && ((cnt_next == FULL_C) || last_bit);
    pk_pad    = pk_next << (FULL_C - cnt_next);
  end

  // A completed word goes straight to the holding register when it is free
  // (or being drained this cycle); otherwise it parks in the packer, which
  // then reports full and stalls the chain until the holding register drains.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      pk_data    <= '0;
      pk_cnt     <= '0;
      pk_last    <= 1'b0;
      hold_data  <= '0;
      hold_valid <= 1'b0;
      hold_last  <= 1'b0;
    end else begin
      if (handshake) begin
        hold_valid <= 1'b0;
      end
      if (word_done) begin
        if (hold_free) begin
          hold_data  <= pk_pad;
          hold_valid <= 1'b1;
          hold_last  <= last_bit;
          pk_data    <= '0;
          pk_cnt     <= '0;
          pk_last    <= 1'b0;
        end else begin
          pk_data <= pk_pad;
          pk_cnt  <= FULL_C;
          pk_last <= last_bit;
        end
      end else if (shift) begin
        pk_data <= pk_next;
        pk_cnt  <= cnt_next;
      end else if (pk_full && handshake) begin
        hold_data  <= pk_data;
        hold_valid <= 1'b1;
        hold_last  <= pk_last;
        pk_data    <= '0;
        pk_cnt     <= '0;
        pk_last    <= 1'b0;
      end
    end
  end

  assign rb_data    = hold_data;
  assign rb_valid   = hold_valid;
  assign rb_last    = hold_valid && hold_last;
  assign can_accept = !pk_full;
  assign empty      = (pk_cnt == '0) && !hold_valid;

endmodule

// File: rtl/ccff_chain_loader.sv
// Configuration-chain master: serialises bitstream words into ccff_head and
// repacks the displaced chain contents from ccff_tail into a readback stream.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 1024,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              chain_shift_en,
  output logic [DATA_W-1:0] rb_data,
  output logic              rb_valid,
  input  logic              rb_ready,
  output logic              rb_last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned WB_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] DW_C   = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CONE_C = CNT_W'(1);
  localparam logic [WB_W-1:0]  WFULL_C = WB_W'(DATA_W);
  localparam logic [WB_W-1:0]  WONE_C  = WB_W'(1);

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  fill_cnt;
  logic [CNT_W-1:0]  remaining;
  logic [DATA_W-1:0] word_reg;
  logic [WB_W-1:0]   word_bits;
  logic [WB_W-1:0]   load_bits;
  logic              shift;
  logic              accept;
  logic              restart;
  logic              last_bit;
  logic              can_accept;
  logic              rb_empty;

  // State register.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus shift/accept qualification.
  always_comb begin
    state_nxt = state;
    remaining = LEN_C - fill_cnt;
    load_bits = (remaining >= DW_C) ? WFULL_C : WB_W'(remaining);
    restart   = start && ((state == IDLE) || (state == DONE));
    last_bit  = (bit_cnt == LAST_C);
    shift     = (state == LOAD) && (word_bits != '0) && can_accept;
    // The word register also counts as empty while its final bit shifts
    // out, so the refill lands with no bubble.
    in_ready  = (state == LOAD) && (remaining != '0) &&
                ((word_bits == '0) || ((word_bits == WONE_C) && shift));
    accept    = in_valid && in_ready;
    unique case (state)
      IDLE, DONE: if (start) state_nxt = LOAD;
      LOAD:       if (bit_cnt == LEN_C) state_nxt = DRAIN;
      DRAIN:      if (rb_empty) state_nxt = DONE;
    endcase
    if (abort) begin
      state_nxt = IDLE;
    end
  end

  // Word register and counters; a partial final word is loaded with only its
  // useful bit count so the unused LSBs never reach the chain.
  always_ff @(posedge prog_clk) begin
    if (prog_reset || abort || restart) begin
      bit_cnt   <= '0;
      fill_cnt  <= '0;
      word_reg  <= '0;
      word_bits <= '0;
    end else begin
      if (shift) begin
        bit_cnt <= bit_cnt + CONE_C;
      end
      if (accept) begin
        word_reg  <= in_data;
        word_bits <= load_bits;
        fill_cnt  <= fill_cnt + CNT_W'(load_bits);
      end else if (shift) begin
        word_reg  <= {word_reg[DATA_W-2:0], 1'b0};
        word_bits <= word_bits - WONE_C;
      end
    end
  end

  ccff_rb_packer #(
    .DATA_W(DATA_W)
  ) u_packer (
    .clk        (prog_clk),
    .rst        (prog_reset),
    .clear      (abort),
    .shift      (shift),
    .tail       (ccff_tail),
    .last_bit   (last_bit),
    .rb_ready   (rb_ready),
    .rb_data    (rb_data),
    .rb_valid   (rb_valid),
    .rb_last    (rb_last),
    .can_accept (can_accept),
    .empty      (rb_empty)
  );

  assign ccff_head      = word_reg[DATA_W-1];
  assign chain_shift_en = shift;
  assign busy           = (state == LOAD) || (state == DRAIN);
  assign done           = (state == DONE);

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader with a 20-flop chain and 8-bit words.
module tb_ccff_chain_loader;
  import ccff_loader_pkg::*;

  localparam int LEN = 20;
  localparam int DW  = 8;

  logic          clk = 1'b0;
  logic          prog_reset, start, abort, in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic          ccff_head, ccff_tail, chain_shift_en;
  logic [DW-1:0] rb_data;
  logic          rb_valid, rb_ready, rb_last, busy, done;

  ccff_chain_loader #(
    .CHAIN_LEN(LEN),
    .DATA_W   (DW)
  ) dut (
    .prog_clk      (clk),
    .prog_reset    (prog_reset),
    .start         (start),
    .abort         (abort),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .ccff_head     (ccff_head),
    .ccff_tail     (ccff_tail),
    .chain_shift_en(chain_shift_en),
    .rb_data       (rb_data),
    .rb_valid      (rb_valid),
    .rb_ready      (rb_ready),
    .rb_last       (rb_last),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  // External fabric chain: shifts one place on each enabled edge.
  logic [LEN-1:0] chain;
  logic           preload_req;
  always @(posedge clk) begin
    if (preload_req) chain <= 20'hABCDE;
    else if (chain_shift_en) chain <= {chain[LEN-2:0], ccff_head};
  end
  assign ccff_tail = chain[LEN-1];

  int errors = 0;
  int checks = 0;

  // Model state for the current load.
  logic          exp_bits[$];
  logic [DW-1:0] exp_rb[$];
  logic [DW-1:0] src[$];
  logic [DW-1:0] got_rb[0:7];
  int            src_idx = 0;
  int            load_gen = 0;
  int            seen_gen = 0;
  int            shift_idx = 0;
  int            rb_idx = 0;
  logic          hold_wait = 1'b0;
  logic [DW-1:0] held_data;
  logic          want_valid;

  // Per-step samples of the DUT outputs.
  logic          se_s, head_s, busy_s, done_s, rdy_s, rbv_s, rbl_s;
  logic [DW-1:0] rbd_s;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // One clock: drive the source word, sample outputs, retire an accepted word.
  task automatic step();
    logic acc;
    in_valid = want_valid && (src_idx < src.size());
    in_data  = (src_idx < src.size()) ? src[src_idx] : '0;
    #1;
    se_s   = chain_shift_en;
    head_s = ccff_head;
    busy_s = busy;
    done_s = done;
    rdy_s  = in_ready;
    rbv_s  = rb_valid;
    rbd_s  = rb_data;
    rbl_s  = rb_last;
    acc    = in_valid && in_ready;
    @(posedge clk);
    if (acc) src_idx++;
    @(negedge clk);
  endtask

  // Builds the expected head stream from the words to be sent and the
  // expected readback from the chain as it stands, then pulses start.
  task automatic begin_load();
    logic [DW-1:0] w;
    int idx;
    exp_bits.delete();
    exp_rb.delete();
    foreach (src[i]) begin
      w = src[i];
      for (int b = DW - 1; b >= 0; b--)
        if (exp_bits.size() < LEN) exp_bits.push_back(w[b]);
    end
    for (int k = 0; k < int'(word_count(LEN, DW)); k++) begin
      w = '0;
      for (int b = 0; b < DW; b++) begin
        idx = k * DW + b;
        if (idx < LEN) w[DW-1-b] = chain[LEN-1-idx];
      end
      exp_rb.push_back(w);
    end
    src_idx = 0;
    load_gen++;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_until_done(input int max, input string name);
    int n = 0;
    while (!done && n < max) begin
      step();
      n++;
    end
    check(name, done, 1);
  endtask

  task automatic preload();
    preload_req = 1'b1;
    step();
    preload_req = 1'b0;
  endtask

  // Every cycle: head bit against the model stream, readback handshakes
  // against the model words, holding register stability under backpressure.
  task automatic compare_loop();
    forever begin
      @(negedge clk);
      #2;
      if (load_gen != seen_gen) begin
        seen_gen  = load_gen;
        shift_idx = 0;
        rb_idx    = 0;
        hold_wait = 1'b0;
      end
      if (chain_shift_en) begin
        if (shift_idx < exp_bits.size()) check("head_bit", ccff_head, exp_bits[shift_idx]);
        else check("shift_overrun", shift_idx, exp_bits.size() - 1);
        shift_idx++;
      end
      if (hold_wait) begin
        check("rb_hold_valid", rb_valid, 1);
        check("rb_hold_data", rb_data, held_data);
      end
      if (rb_valid && rb_ready) begin
        if (rb_idx < exp_rb.size()) begin
          check("rb_word", rb_data, exp_rb[rb_idx]);
          check("rb_last", rb_last, (rb_idx == exp_rb.size() - 1));
        end else begin
          check("rb_overrun", rb_idx, exp_rb.size() - 1);
        end
        if (rb_idx < 8) got_rb[rb_idx] = rb_data;
        rb_idx++;
      end
      hold_wait = rb_valid && !rb_ready && !abort && !prog_reset;
      held_data = rb_data;
    end
  endtask

  initial begin
    logic head_ref;
    fork
      compare_loop();
    join_none
    prog_reset = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
    rb_ready = 1'b1; want_valid = 1'b1; preload_req = 1'b1;
    src = '{8'h12, 8'h34, 8'h50};
    @(negedge clk);
    step();
    preload_req = 1'b0;
    step();
    check("rst_in_ready", rdy_s, 0);
    check("rst_head", head_s, 0);
    check("rst_shift_en", se_s, 0);
    check("rst_rb_valid", rbv_s, 0);
    check("rst_rb_data", rbd_s, 0);
    check("rst_rb_last", rbl_s, 0);
    check("rst_busy", busy_s, 0);
    check("rst_done", done_s, 0);
    prog_reset = 1'b0;
    step();

    // Basic load with latency, final chain and readback literals.
    preload();
    begin_load();
    check("model_rb2", exp_rb[2], 8'hE0);
    step();
    check("lat_c0_shift", se_s, 0);
    check("lat_c0_ready", rdy_s, 1);
    step();
    check("lat_c1_shift", se_s, 1);
    run_until_done(80, "t1_done");
    check("t1_chain", chain, 20'h12345);
    check("t1_shifts", shift_idx, 20);
    check("t1_words", rb_idx, 3);
    check("t1_rb0", got_rb[0], 8'hAB);
    check("t1_rb1", got_rb[1], 8'hCD);
    check("t1_rb2", got_rb[2], 8'hE0);
    check("t1_busy", busy, 0);

    // Source stall after the first word.
    preload();
    begin_load();
    step();
    want_valid = 1'b0;
    head_ref = 1'b0;
    for (int i = 0; i < 13; i++) begin
      step();
      if (i == 8) head_ref = head_s;
      if (i >= 8) begin
        check("t2_stall_shift", se_s, 0);
        check("t2_stall_head", head_s, head_ref);
      end
    end
    check("t2_stall_count", shift_idx, 8);
    want_valid = 1'b1;
    run_until_done(80, "t2_done");
    check("t2_chain", chain, 20'h12345);
    check("t2_words", rb_idx, 3);

    // Readback backpressure.
    preload();
    rb_ready = 1'b0;
    begin_load();
    for (int i = 0; i < 40; i++) step();
    check("t3_stall_count", shift_idx, 16);
    check("t3_stall_shift", se_s, 0);
    check("t3_rb_valid", rbv_s, 1);
    rb_ready = 1'b1;
    run_until_done(80, "t3_done");
    check("t3_chain", chain, 20'h12345);
    check("t3_rb0", got_rb[0], 8'hAB);
    check("t3_rb2", got_rb[2], 8'hE0);

    // Abort after seven shifts, then a clean reload.
    preload();
    begin_load();
    for (int i = 0; i < 30 && shift_idx < 7; i++) step();
    check("t4_reach7", shift_idx, 7);
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();
    check("t4_busy", busy_s, 0);
    check("t4_rb_valid", rbv_s, 0);
    check("t4_done", done_s, 0);
    begin_load();
    run_until_done(80, "t4_done_reload");
    check("t4_chain", chain, 20'h12345);
    check("t4_shifts", shift_idx, 20);

    // start during LOAD is ignored; start with abort goes idle.
    preload();
    begin_load();
    for (int i = 0; i < 5; i++) step();
    start = 1'b1;
    step();
    start = 1'b0;
    run_until_done(80, "t5_done");
    check("t5_chain", chain, 20'h12345);
    check("t5_shifts", shift_idx, 20);
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    step();
    check("t5_sa_busy", busy_s, 0);
    check("t5_sa_done", done_s, 0);

    // Reset mid-load, then a full reload.
    preload();
    begin_load();
    for (int i = 0; i < 6; i++) step();
    prog_reset = 1'b1;
    step();
    prog_reset = 1'b0;
    step();
    check("t6_in_ready", rdy_s, 0);
    check("t6_head", head_s, 0);
    check("t6_shift_en", se_s, 0);
    check("t6_rb_valid", rbv_s, 0);
    check("t6_rb_data", rbd_s, 0);
    check("t6_rb_last", rbl_s, 0);
    check("t6_busy", busy_s, 0);
    check("t6_done", done_s, 0);
    begin_load();
    run_until_done(80, "t6_done_reload");
    check("t6_chain", chain, 20'h12345);
    check("t6_shifts", shift_idx, 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Drives the configuration-chain protocol from the far end. Tiles consume bits on ccff_head and emit them on ccff_tail; this block is the master that produces and collects those bits.
- Accepts a bitstream as DATA_W-bit words over a valid/ready stream and serialises it into ccff_head, one bit per enabled prog_clk cycle.
- Captures the displaced chain contents from ccff_tail and repacks them into a readback stream.
- Sits between the bitstream DMA/host interface and the head of the fabric configuration chain.

Parameters:
- CHAIN_LEN, 1024: total flops in the chain; number of shift cycles per load.
- DATA_W, 8: stream word width, both directions.
- CNT_W, $clog2(CHAIN_LEN+1): bit-counter width (derived; do not override).

Ports:
- prog_clk  in  1  configuration clock; all state on the rising edge.
- prog_reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE or DONE.
- abort  in  1  synchronous abort; returns to IDLE next cycle.
- in_data  in  DATA_W  bitstream word; bit DATA_W-1 is shifted first.
- in_valid  in  1  in_data valid.
- in_ready  out  1  word accepted when in_valid&&in_ready.
- ccff_head  out  1  serial bit into the chain head.
- ccff_tail  in  1  serial bit from the chain tail.
- chain_shift_en  out  1  clock enable for the chain (feeds external ICG); the chain shifts on an edge only when this is high.
- rb_data  out  DATA_W  readback word; first captured bit sits in bit DATA_W-1.
- rb_valid  out  1  rb_data valid.
- rb_ready  in  1  readback consumer ready.
- rb_last  out  1  marks the final readback word of a load.
- busy  out  1  high in LOAD and DRAIN.
- done  out  1  level; high in DONE until the next start.

Behaviour:
- Reset values: in_ready=0, ccff_head=0, chain_shift_en=0, rb_valid=0, rb_data=0, rb_last=0, busy=0, done=0; state=IDLE; counters=0. Reset does not clear chain contents.
- States and transitions:
  - IDLE: start goes to LOAD. bit_cnt:=0, word register emptied.
  - LOAD: runs until bit_cnt==CHAIN_LEN, then goes to DRAIN.
  - DRAIN: waits for the readback holding register to empty, then goes to DONE.
  - DONE: start re-enters LOAD.
  - abort in any state goes to IDLE. Queued and partial words are discarded, and rb_valid drops.
- start is ignored in LOAD and DRAIN. If start and abort are high together, abort wins.
- in_ready=1 only in LOAD, when the word register is empty and remaining bits exceed 0. A word loads the cycle after acceptance.
- Shift cycle: chain_shift_en=1 iff all of the following hold:
  - state is LOAD;
  - the word register holds at least 1 bit;
  - the readback packer can accept a bit.
- In a shift cycle, ccff_head is the current word-register MSB, combinational from registered state, valid the same cycle. ccff_tail is sampled on that same edge into the packer. bit_cnt increments and the word register shifts left.
- Throughput: one bit/cycle sustained when in_valid and rb_ready stay high. Refill costs 0 bubbles, because the next word is accepted during the last bit of the current word.
- Partial last word (CHAIN_LEN mod DATA_W ≠ 0): only the top (CHAIN_LEN mod DATA_W) bits are shifted and the remainder is discarded. No extra word is requested.
- Readback packer:
  - Collects DATA_W bits, then moves the word to the holding register, which asserts rb_valid.
  - The holding register is stable while rb_valid && !rb_ready.
  - The packer stalls shifting only when it is full and the holding register is occupied.
  - The final word is zero-padded in its LSBs and carries rb_last=1.
  - Total readback words = ceil(CHAIN_LEN/DATA_W).
- Load latency: first chain_shift_en no earlier than 2 cycles after start (1 cycle to enter LOAD, 1 cycle to accept the first word).
- in_valid low stalls shifting with chain_shift_en=0 and ccff_head held. There is no timeout.
- Reset or abort mid-load leaves the chain partially shifted; software reloads.

Decomposition:
- Package ccff_loader_pkg holds: the state enum (IDLE, LOAD, DRAIN, DONE) and a localparam helper function for word count ceil(len/w).
- One sub-module: ccff_rb_packer. It handles serial-to-parallel conversion, the holding register, rb_valid/rb_ready and rb_last, and outputs can_accept.

Test Plan:
- CHAIN_LEN=20, DATA_W=8, bench chain model preloaded with 0xABCDE. Send 0x12,0x34,0x50 with rb_ready=1 → exactly 20 shift cycles, chain holds 0x12345, readback words 0xAB,0xCD,0xE0 with rb_last on the third, done=1.
- Same setup with in_valid low for 5 cycles after the first word → chain_shift_en=0 for those cycles, ccff_head stable, final chain contents unchanged 0x12345.
- rb_ready=0 throughout → shifting stops after 16 bits (packer and holding register both full). Releasing rb_ready completes the load with correct data.
- abort asserted after 7 shifts → next cycle in IDLE, busy=0, rb_valid=0. A new start reloads all 20 bits correctly.
- start pulsed in LOAD → ignored. start and abort in the same cycle → IDLE.
- prog_reset mid-LOAD → all outputs reach their reset values the next cycle. A subsequent start performs a full 20-shift load.
